and_op: RTL and testbench
=========================

// Module: and_op
// PURPOSE
//   Registered WIDTH-bit bitwise logical AND unit for the execute stage's logical-operation path.
//   Computes y = a AND b, with optional complement of operand b (AND-complement) and optional
//   negation of the result (NAND).
//   Output is registered, with one cycle of latency and a valid bit and zero flag alongside.
//   Consumed by the ALU result mux.
// PARAMETERS
//   WIDTH      24   operand/result width; bit 0 is the MSB ([0:WIDTH-1] ordering)
// PORTS
//   clk        in   1       single clock; all state updates on rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   in_valid   in   1       a/b/cmp_b/neg_res qualify this cycle
//   a          in   WIDTH   operand A
//   b          in   WIDTH   operand B
//   cmp_b      in   1       1: use ~b in place of b
//   neg_res    in   1       1: invert final result (NAND form)
//   out_valid  out  1       y/zero hold a result computed from an in_valid cycle
//   y          out  WIDTH   registered result
//   zero       out  1       registered; 1 when y == 0
// BEHAVIOUR
//   - Combinational core: t = a & (cmp_b ? ~b : b); r = neg_res ? ~t : t.
//   - Pure bitwise operation: no carry or cross-bit terms; bit i of r depends only on bit i of the inputs.
//   - Latency 1: on the clk rising edge with in_valid=1, y<=r, zero<=(r==0), out_valid<=1.
//   - On a rising edge with in_valid=0: out_valid<=0; y and zero hold their previous values.
//   - No backpressure. A new result is accepted every cycle, and back-to-back operands produce
//     back-to-back results.
//   - Reset:
//     - rst_n low asynchronously forces y=0, zero=1, out_valid=0, regardless of clk.
//     - Reset asserted mid-stream discards the in-flight result.
//     - The first valid result appears one edge after rst_n deasserts and in_valid is sampled high.
//   - X on a/b while in_valid=0 must not propagate to y.
//   - Boundaries:
//     - b=0 gives y=0, zero=1.
//     - b=all-ones gives y=a.
//     - cmp_b=1 with b=all-ones gives y=0.
//     - neg_res=1 with a=b=all-ones gives y=0, zero=1.
// STRUCTURE
//   - Shared package (cpu_pkg): WORD_WIDTH=24 constant and word typedef; WIDTH defaults from it.
//   - One natural sub-module: and_op_core holds the combinational t/r logic and its zero detect.
//   - and_op wraps and_op_core and adds the async-reset output register and the valid bit.
// TESTING
//   1 a=F010FF, b=000000, cmp_b=0, neg_res=0 -> next edge: y=000000, zero=1, out_valid=1.
//   2 a=F010FF, b=FFFFFF -> y=F010FF, zero=0; a=F010FF, b=FFF000 -> y=F01000.
//   3 a=F010FF, b=FFF000, cmp_b=1 -> y=0000FF; then neg_res=1, cmp_b=0, b=FFFFFF -> y=0FEF00.
//   4 back-to-back in_valid on 3 cycles with the vectors of test 2 ->
//     results on 3 consecutive edges in order; then in_valid=0 -> out_valid=0, y holds.
//   5 assert rst_n low between clock edges while out_valid=1 ->
//     y=000000, zero=1, out_valid=0 immediately; release -> first result after next valid edge.
//   6 random a/b/cmp_b/neg_res for 1000 cycles vs reference model;
//     zero must always equal (y==0).

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared execute-stage definitions: the machine word width and the word
//   type used by the datapath units. Word bits are numbered [0:WIDTH-1],
//   so bit 0 is the MSB.
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int WORD_WIDTH = 24;

    typedef logic [0:WORD_WIDTH-1] word_t;

    // True when every bit of a word is clear.
    function automatic logic word_is_zero(input word_t w);
        return (w == {WORD_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/and_op_if.sv
// ----------------------------------------------------------------------------
// and_op_if
//   Operand/result bundle for the logical AND unit.
//   master : producer side (drives operands, receives result)
//   slave  : the and_op unit (receives operands, drives result)
//   Signals:
//     in_valid          operands qualify this cycle
//     a, b              operands, [0:WIDTH-1] ordering
//     cmp_b             use ~b in place of b
//     neg_res           invert the final result (NAND form)
//     out_valid         y/zero hold a result from an in_valid cycle
//     y                 registered result
//     zero              registered, 1 when y == 0
// ----------------------------------------------------------------------------
interface and_op_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) ();

    logic               in_valid;
    logic [0:WIDTH-1]   a;
    logic [0:WIDTH-1]   b;
    logic               cmp_b;
    logic               neg_res;
    logic               out_valid;
    logic [0:WIDTH-1]   y;
    logic               zero;

    modport master (
        output in_valid, a, b, cmp_b, neg_res,
        input  out_valid, y, zero
    );

    modport slave (
        input  in_valid, a, b, cmp_b, neg_res,
        output out_valid, y, zero
    );

endinterface

// File: rtl/and_op_core.sv
// ----------------------------------------------------------------------------
// and_op_core
//   Combinational core of the logical AND unit.
//     t = a & (cmp_b ? ~b : b)
//     r = neg_res ? ~t : t
//   Purely bitwise: bit i of r depends only on bit i of the inputs.
//   Ports:
//     a, b      in   WIDTH  operands
//     cmp_b     in   1      complement b before the AND
//     neg_res   in   1      complement the result
//     r         out  WIDTH  result
//     r_zero    out  1      1 when r == 0
// ----------------------------------------------------------------------------
module and_op_core
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             cmp_b,
    input  logic             neg_res,
    output logic [0:WIDTH-1] r,
    output logic             r_zero
);

    logic [0:WIDTH-1] b_sel;
    logic [0:WIDTH-1] t;

    // Operand select, AND, optional result inversion and zero detect.
    always_comb begin
        b_sel  = {WIDTH{1'b0}};
        t      = {WIDTH{1'b0}};
        r      = {WIDTH{1'b0}};
        r_zero = 1'b1;

        if (cmp_b) begin
            b_sel = ~b;
        end else begin
            b_sel = b;
        end

        t = a & b_sel;

        if (neg_res) begin
            r = ~t;
        end else begin
            r = t;
        end

        r_zero = (r == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/and_op.sv
// ----------------------------------------------------------------------------
// and_op
//   Registered WIDTH-bit bitwise AND unit (AND / AND-complement / NAND) for
//   the execute stage's logical path. One cycle of latency, no backpressure:
//   every in_valid cycle produces a result on the following edge.
//   Ports:
//     clk     in   1   rising-edge clock
//     rst_n   in   1   asynchronous active-low reset (y=0, zero=1, out_valid=0)
//     bus     slave modport of and_op_if (operands in, result out)
// ----------------------------------------------------------------------------
module and_op
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic     clk,
    input  logic     rst_n,
    and_op_if.slave  bus
);

    logic [0:WIDTH-1] r;
    logic             r_zero;

    logic [0:WIDTH-1] y_q;
    logic             zero_q;
    logic             valid_q;

    and_op_core #(
        .WIDTH   (WIDTH)
    ) u_core (
        .a       (bus.a),
        .b       (bus.b),
        .cmp_b   (bus.cmp_b),
        .neg_res (bus.neg_res),
        .r       (r),
        .r_zero  (r_zero)
    );

    // Result register: y/zero only load on in_valid cycles, so operands
    // (including X) seen while in_valid is low never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= {WIDTH{1'b0}};
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else if (bus.in_valid) begin
            y_q     <= r;
            zero_q  <= r_zero;
            valid_q <= 1'b1;
        end else begin
            y_q     <= y_q;
            zero_q  <= zero_q;
            valid_q <= 1'b0;
        end
    end

    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_and_op.sv
// ----------------------------------------------------------------------------
// tb_and_op
//   Self-checking bench for and_op: directed vectors, back-to-back issue,
//   mid-stream asynchronous reset and a randomized run against a per-bit
//   truth-table reference model.
// ----------------------------------------------------------------------------
module tb_and_op;

    localparam int W = 24;

    logic clk;
    logic rst_n;

    int tests;
    int fails;

    // Reference model state
    logic [W-1:0] exp_y;
    logic         exp_zero;
    logic         exp_valid;

    and_op_if #(.WIDTH(W)) bus ();

    and_op #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each result bit from the operation's truth table.
    function automatic logic [W-1:0] ref_and(input logic [W-1:0] av, input logic [W-1:0] bv,
                                             input logic c, input logic n);
        logic [W-1:0] res;
        res = '0;
        for (int i = 0; i < W; i++) begin
            logic bit_b;
            logic bit_t;
            bit_b = c ? !bv[i] : bv[i];
            bit_t = av[i] && bit_b;
            res[i] = n ? !bit_t : bit_t;
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, {{(W-1){1'b0}}, bus.out_valid}, {{(W-1){1'b0}}, exp_valid});
        check({tag, ".y"},         bus.y,                             exp_y);
        check({tag, ".zero"},      {{(W-1){1'b0}}, bus.zero},      {{(W-1){1'b0}}, exp_zero});
    endtask

    // Drive one cycle of inputs at negedge, then check the outputs just after posedge.
    task automatic step(input string tag, input logic v, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic c, input logic n);
        @(negedge clk);
        bus.in_valid = v;
        bus.cmp_b    = c;
        bus.neg_res  = n;
        if (v) begin
            bus.a = av;
            bus.b = bv;
        end else begin
            bus.a = 'x;
            bus.b = 'x;
        end
        @(posedge clk);
        #1;
        if (v) begin
            exp_y     = ref_and(av, bv, c, n);
            exp_zero  = (exp_y == '0);
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        check_outputs(tag);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rv;
        logic         rc;
        logic         rn;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cmp_b = 1'b0;
        bus.neg_res = 1'b0;
        exp_y = '0;
        exp_zero = 1'b1;
        exp_valid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, including literal expectations
        step("t1_b_zero", 1'b1, 24'hF010FF, 24'h000000, 1'b0, 1'b0);
        check("t1_lit", bus.y, 24'h000000);
        step("t2_b_ones", 1'b1, 24'hF010FF, 24'hFFFFFF, 1'b0, 1'b0);
        check("t2_lit_a", bus.y, 24'hF010FF);
        step("t2_b_mask", 1'b1, 24'hF010FF, 24'hFFF000, 1'b0, 1'b0);
        check("t2_lit_b", bus.y, 24'hF01000);
        step("t3_cmp", 1'b1, 24'hF010FF, 24'hFFF000, 1'b1, 1'b0);
        check("t3_lit_a", bus.y, 24'h0000FF);
        step("t3_neg", 1'b1, 24'hF010FF, 24'hFFFFFF, 1'b0, 1'b1);
        check("t3_lit_b", bus.y, 24'h0FEF00);
        step("bnd_cmp_ones", 1'b1, 24'hABCDEF, 24'hFFFFFF, 1'b1, 1'b0);
        check("bnd_cmp_lit", bus.y, 24'h000000);
        step("bnd_nand_ones", 1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1);
        check("bnd_nand_lit", {{(W-1){1'b0}}, bus.zero}, 24'h000001);

        // Back-to-back issue, then idle with hold
        step("t4_b2b_0", 1'b1, 24'hF010FF, 24'hFFFFFF, 1'b0, 1'b0);
        step("t4_b2b_1", 1'b1, 24'hF010FF, 24'hFFF000, 1'b0, 1'b0);
        step("t4_b2b_2", 1'b1, 24'hF010FF, 24'h000000, 1'b0, 1'b0);
        step("t4_b2b_3", 1'b1, 24'hF010FF, 24'hFFF000, 1'b0, 1'b0);
        step("t4_idle", 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0);
        check("t4_hold_lit", bus.y, 24'hF01000);
        step("t4_idle2", 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0);

        // Mid-stream asynchronous reset between edges
        step("t5_pre", 1'b1, 24'h123456, 24'hFFFFFF, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 24'h777777;
        bus.b = 24'hFFFFFF;
        #2;
        rst_n = 1'b0;
        #1;
        exp_y = '0;
        exp_zero = 1'b1;
        exp_valid = 1'b0;
        check_outputs("t5_async");
        @(posedge clk);
        #1;
        check_outputs("t5_held");
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("t5_rel_idle");
        step("t5_first", 1'b1, 24'h00FF00, 24'h0F0F0F, 1'b0, 1'b0);

        // Randomized run
        for (int i = 0; i < 1000; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rn = 1'($urandom);
            if ($urandom_range(0, 15) == 0) rb = '0;
            if ($urandom_range(0, 15) == 0) rb = '1;
            step("rand", rv, ra, rb, rc, rn);
            check("rand_zero_flag", {{(W-1){1'b0}}, bus.zero},
                  {{(W-1){1'b0}}, (bus.y == '0)});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
